// File: rtl/alu_exe_unit.sv
// Single-cycle integer ALU execution stage: computes the result of an issued
// instruction and raises registered completion/write strobes one cycle later.
module alu_exe_unit #(
  parameter int DATA_LEN     = 32,
  parameter int ALU_OP_WIDTH = 4
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic                    if_write_rrf_i,
  input  logic [ALU_OP_WIDTH-1:0] alu_op_i,
  input  logic [DATA_LEN-1:0]     src1_i,
  input  logic [DATA_LEN-1:0]     src2_i,
  input  logic                    issue_i,
  output logic [DATA_LEN-1:0]     result_o,
  output logic                    reorder_buffer_we_o,
  output logic                    rename_register_we_o
);

  localparam logic [ALU_OP_WIDTH-1:0] OP_ADD  = ALU_OP_WIDTH'(0);
  localparam logic [ALU_OP_WIDTH-1:0] OP_SUB  = ALU_OP_WIDTH'(1);
  localparam logic [ALU_OP_WIDTH-1:0] OP_SLL  = ALU_OP_WIDTH'(2);
  localparam logic [ALU_OP_WIDTH-1:0] OP_SLT  = ALU_OP_WIDTH'(3);
  localparam logic [ALU_OP_WIDTH-1:0] OP_SLTU = ALU_OP_WIDTH'(4);
  localparam logic [ALU_OP_WIDTH-1:0] OP_XOR  = ALU_OP_WIDTH'(5);
  localparam logic [ALU_OP_WIDTH-1:0] OP_SRL  = ALU_OP_WIDTH'(6);
  localparam logic [ALU_OP_WIDTH-1:0] OP_SRA  = ALU_OP_WIDTH'(7);
  localparam logic [ALU_OP_WIDTH-1:0] OP_OR   = ALU_OP_WIDTH'(8);
  localparam logic [ALU_OP_WIDTH-1:0] OP_AND  = ALU_OP_WIDTH'(9);

  logic [DATA_LEN-1:0] result_q, result_d;
  logic                rob_we_q, rob_we_d;
  logic                rrf_we_q, rrf_we_d;
  logic [DATA_LEN-1:0] alu_val;
  logic [4:0]          shamt;
  logic                lt_s, lt_u;

  assign shamt = src2_i[4:0];
  assign lt_s  = $signed(src1_i) < $signed(src2_i);
  assign lt_u  = src1_i < src2_i;

  always_comb begin
    alu_val = '0;
    case (alu_op_i)
      OP_ADD:  alu_val = src1_i + src2_i;
      OP_SUB:  alu_val = src1_i - src2_i;
      OP_SLL:  alu_val = src1_i << shamt;
      OP_SLT:  alu_val = {{(DATA_LEN-1){1'b0}}, lt_s};
      OP_SLTU: alu_val = {{(DATA_LEN-1){1'b0}}, lt_u};
      OP_XOR:  alu_val = src1_i ^ src2_i;
      OP_SRL:  alu_val = src1_i >> shamt;
      OP_SRA:  alu_val = DATA_LEN'($signed(src1_i) >>> shamt);
      OP_OR:   alu_val = src1_i | src2_i;
      OP_AND:  alu_val = src1_i & src2_i;
      default: alu_val = '0;
    endcase
  end

  // Result holds while idle; strobes are cleared every non-issue cycle.
  always_comb begin
    result_d = result_q;
    rob_we_d = 1'b0;
    rrf_we_d = 1'b0;
    if (issue_i) begin
      result_d = alu_val;
      rob_we_d = 1'b1;
      rrf_we_d = if_write_rrf_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      result_q <= '0;
      rob_we_q <= 1'b0;
      rrf_we_q <= 1'b0;
    end else begin
      result_q <= result_d;
      rob_we_q <= rob_we_d;
      rrf_we_q <= rrf_we_d;
    end
  end

  assign result_o             = result_q;
  assign reorder_buffer_we_o  = rob_we_q;
  assign rename_register_we_o = rrf_we_q;

endmodule

// File: tb/tb_alu_exe_unit.sv
// Bench for alu_exe_unit: table of opcode vectors plus hand-written
// reset/idle sequences, checked through an expected-result queue.
module tb_alu_exe_unit;

  logic        clk;
  logic        reset_i;
  logic        if_write_rrf_i;
  logic [3:0]  alu_op_i;
  logic [31:0] src1_i;
  logic [31:0] src2_i;
  logic        issue_i;
  logic [31:0] result_o;
  logic        reorder_buffer_we_o;
  logic        rename_register_we_o;

  alu_exe_unit #(.DATA_LEN(32), .ALU_OP_WIDTH(4)) dut (
    .clk_i               (clk),
    .reset_i             (reset_i),
    .if_write_rrf_i      (if_write_rrf_i),
    .alu_op_i            (alu_op_i),
    .src1_i              (src1_i),
    .src2_i              (src2_i),
    .issue_i             (issue_i),
    .result_o            (result_o),
    .reorder_buffer_we_o (reorder_buffer_we_o),
    .rename_register_we_o(rename_register_we_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] res;
    logic        rob;
    logic        rrf;
  } exp_t;

  typedef struct {
    string       name;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        wr;
    logic [31:0] res;
  } vec_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] model_res = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, req);
    end
  endtask

  // Drive one cycle of inputs at the falling edge and queue what the
  // outputs must show after the following rising edge.
  task automatic drive(input logic rst, input logic iss, input logic [3:0] op,
                       input logic [31:0] a, input logic [31:0] b, input logic wr,
                       input logic [31:0] exp_res, input string nm);
    exp_t e;
    @(negedge clk);
    reset_i        = rst;
    issue_i        = iss;
    alu_op_i       = op;
    src1_i         = a;
    src2_i         = b;
    if_write_rrf_i = wr;
    e.name = nm;
    if (rst) begin
      model_res = '0;
      e.res = '0; e.rob = 1'b0; e.rrf = 1'b0;
    end else if (iss) begin
      model_res = exp_res;
      e.res = exp_res; e.rob = 1'b1; e.rrf = wr;
    end else begin
      e.res = model_res; e.rob = 1'b0; e.rrf = 1'b0;
    end
    sb.push_back(e);
  endtask

  always @(posedge clk) begin
    #1;
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      chk({e.name, ".result"}, result_o, e.res);
      chk({e.name, ".rob_we"}, {31'b0, reorder_buffer_we_o}, {31'b0, e.rob});
      chk({e.name, ".rrf_we"}, {31'b0, rename_register_we_o}, {31'b0, e.rrf});
      chk({e.name, ".rrf_implies_rob"},
          {31'b0, rename_register_we_o & ~reorder_buffer_we_o}, 32'd0);
    end
  end

  vec_t vecs[$];

  initial begin
    vecs = '{
      '{"add",       4'd0,  32'd10,         32'd12,         1'b1, 32'd22},
      '{"sub",       4'd1,  32'd5,          32'd7,          1'b0, 32'hFFFF_FFFE},
      '{"sra",       4'd7,  32'h8000_0000,  32'h0000_0024,  1'b1, 32'hF800_0000},
      '{"srl",       4'd6,  32'h8000_0000,  32'h0000_0024,  1'b1, 32'h0800_0000},
      '{"sll",       4'd2,  32'h0000_0001,  32'h0000_003F,  1'b0, 32'h8000_0000},
      '{"slt",       4'd3,  32'hFFFF_FFFF,  32'd1,          1'b1, 32'd1},
      '{"sltu",      4'd4,  32'hFFFF_FFFF,  32'd1,          1'b1, 32'd0},
      '{"slt_rev",   4'd3,  32'd1,          32'hFFFF_FFFF,  1'b1, 32'd0},
      '{"sltu_rev",  4'd4,  32'd1,          32'hFFFF_FFFF,  1'b1, 32'd1},
      '{"xor",       4'd5,  32'hF0F0_F0F0,  32'hFF00_FF00,  1'b1, 32'h0FF0_0FF0},
      '{"or",        4'd8,  32'hF0F0_F0F0,  32'h0F0F_0000,  1'b0, 32'hFFFF_F0F0},
      '{"and",       4'd9,  32'hF0F0_F0F0,  32'hFF00_FF00,  1'b1, 32'hF000_F000},
      '{"add_wrap",  4'd0,  32'hFFFF_FFFF,  32'd1,          1'b1, 32'd0},
      '{"undef12",   4'd12, 32'h1234_5678,  32'h1111_1111,  1'b1, 32'd0},
      '{"undef15",   4'd15, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  1'b0, 32'd0}
    };

    reset_i = 1'b1; issue_i = 1'b0; alu_op_i = '0;
    src1_i = '0; src2_i = '0; if_write_rrf_i = 1'b0;

    // Reset, one ADD, then reset clears everything.
    drive(1, 0, 4'd0, 32'd0,  32'd0,  0, 32'd0,  "reset");
    drive(0, 1, 4'd0, 32'd10, 32'd12, 1, 32'd22, "seq_add");
    drive(1, 0, 4'd0, 32'd0,  32'd0,  0, 32'd0,  "seq_reset");

    // After reset outputs stay 0 with garbage inputs while idle.
    drive(0, 0, 4'd1, 32'hDEAD_BEEF, 32'h5, 1, 32'd0, "post_reset_idle");

    // Back-to-back table issues.
    foreach (vecs[i])
      drive(0, 1, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].wr, vecs[i].res, vecs[i].name);

    // Issue then idle: result holds, enables drop.
    drive(0, 1, 4'd0, 32'd1, 32'd1, 1, 32'd2, "hold_issue");
    drive(0, 0, 4'd9, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 32'd0, "hold_idle1");
    drive(0, 0, 4'd0, 32'd7, 32'd7, 0, 32'd0, "hold_idle2");

    // Reset while issuing discards the instruction.
    drive(1, 1, 4'd0, 32'd3, 32'd4, 1, 32'd0, "reset_with_issue");
    drive(0, 0, 4'd0, 32'd3, 32'd4, 1, 32'd0, "after_discard");

    @(negedge clk);
    issue_i = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
